// File: rtl/json_emitter_if.sv
// Char-stream interface for json_emitter: start/config in, valid/ready char stream and status out.
interface json_emitter_if;
  logic       start_i;
  logic [7:0] n_i;
  logic [7:0] key_base_i;
  logic       ready_i;
  logic [7:0] char_o;
  logic       valid_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] pair_cnt_o;

  modport master (
    input  start_i, n_i, key_base_i, ready_i,
    output char_o, valid_o, busy_o, done_o, pair_cnt_o
  );

  modport slave (
    output start_i, n_i, key_base_i, ready_i,
    input  char_o, valid_o, busy_o, done_o, pair_cnt_o
  );
endinterface

// File: rtl/json_emitter.sv
// Emits one flat JSON object of n string key/value pairs, one ASCII char per valid/ready transfer.
// Define JSON_SPACE_EN to insert a space after each ':' and each ','.
module json_emitter (
  input logic            clk,
  input logic            reset,
  json_emitter_if.master bus
);

`ifdef JSON_SPACE_EN
  typedef enum logic [3:0] {
    StIdle, StLbrace, StKq1, StKey, StKq2, StColon, StSpC, StVq1, StVal, StVq2,
    StComma, StSpM, StRbrace, StDone
  } state_e;
`else
  typedef enum logic [3:0] {
    StIdle, StLbrace, StKq1, StKey, StKq2, StColon, StVq1, StVal, StVq2,
    StComma, StRbrace, StDone
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] n_q, n_d;
  logic [7:0] kb_q, kb_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] dig_q, dig_d;
  logic [7:0] char_q;
  logic       valid_q, busy_q, done_q;
  logic       xfer;
  logic       last_pair;

  function automatic logic [7:0] state_char(state_e st, logic [7:0] kb, logic [7:0] idx,
                                            logic [3:0] dig);
    case (st)
      StLbrace:                  return 8'h7B;
      StKq1, StKq2, StVq1, StVq2: return 8'h22;
      StKey:                     return kb + idx;
      StColon:                   return 8'h3A;
      StVal:                     return 8'h30 + {4'h0, dig};
      StComma:                   return 8'h2C;
      StRbrace:                  return 8'h7D;
`ifdef JSON_SPACE_EN
      StSpC, StSpM:              return 8'h20;
`endif
      default:                   return 8'h00;
    endcase
  endfunction

  assign xfer      = valid_q & bus.ready_i;
  // cnt_q doubles as the 0-based pair index i
  assign last_pair = ({1'b0, cnt_q} + 9'd1) >= {1'b0, n_q};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    kb_d    = kb_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d = StLbrace;
          n_d     = bus.n_i;
          kb_d    = bus.key_base_i;
          cnt_d   = 8'd0;
          dig_d   = 4'd0;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        if (xfer) begin
          case (state_q)
            StLbrace: state_d = (n_q == 8'd0) ? StRbrace : StKq1;
            StKq1:    state_d = StKey;
            StKey:    state_d = StKq2;
            StKq2:    state_d = StColon;
`ifdef JSON_SPACE_EN
            StColon:  state_d = StSpC;
            StSpC:    state_d = StVq1;
            StComma:  state_d = StSpM;
            StSpM:    state_d = StKq1;
`else
            StColon:  state_d = StVq1;
            StComma:  state_d = StKq1;
`endif
            StVq1:    state_d = StVal;
            StVal:    state_d = StVq2;
            StVq2: begin
              state_d = last_pair ? StRbrace : StComma;
              cnt_d   = cnt_q + 8'd1;
              dig_d   = (dig_q == 4'd9) ? 4'd0 : dig_q + 4'd1;
            end
            StRbrace: state_d = StDone;
            default:  state_d = StIdle;
          endcase
        end
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      n_q     <= 8'd0;
      kb_q    <= 8'd0;
      cnt_q   <= 8'd0;
      dig_q   <= 4'd0;
      char_q  <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      kb_q    <= kb_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      char_q  <= state_char(state_d, kb_d, cnt_d, dig_d);
      valid_q <= (state_d != StIdle) && (state_d != StDone);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
    end
  end

  assign bus.char_o     = char_q;
  assign bus.valid_o    = valid_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.pair_cnt_o = cnt_q;

endmodule
